// File: rtl/k_rpack_pkg_t1.sv
// Shared types and helpers for the read-side width packer.
package k_rpack_pkg_t1;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  function automatic int k_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/k_lane_dec_t1.sv
// One-hot lane enable from the fill count, gated by the write strobe.
module k_lane_dec_t1 #(
  parameter int ratio = 4,
  parameter int cnt_w = 3
) (
  input  logic [cnt_w-1:0] cnt,
  input  logic             we,
  output logic [ratio-1:0] lane_en
);

  always_comb begin
    lane_en = '0;
    for (int k = 0; k < ratio; k++) begin
      lane_en[k] = we && (cnt == cnt_w'(k));
    end
  end

endmodule

// File: rtl/k_rpack_t1.sv
// Packs `ratio` FIFO entries into one wide word with a lane-keep mask;
// a flush closes a partial word early.
module k_rpack_t1
  import k_rpack_pkg_t1::*;
#(
  parameter int data_size = 8,
  parameter int ratio     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [data_size-1:0]       rdata,
  input  logic                       rrdy,
  output logic                       rget,
  input  logic                       flush,
  output logic [data_size*ratio-1:0] odata,
  output logic [ratio-1:0]           okeep,
  output logic                       ovalid,
  input  logic                       oready
);

  localparam int CW = k_clog2(ratio) + 1;
  localparam logic [CW-1:0] LAST = CW'(ratio - 1);

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       flush_pend_q, flush_pend_d;
  logic [data_size*ratio-1:0] odata_q, odata_d;
  logic [ratio-1:0]           okeep_q, okeep_d;

  logic             acc;
  logic             flush_req;
  logic [ratio-1:0] lane_en;

  assign acc       = (state_q == COLLECT) || ((state_q == EMIT) && oready);
  assign rget      = rrdy && acc && !rst;
  assign flush_req = flush || flush_pend_q;

  // In EMIT the count is always zero, so a handshake-cycle pop lands in lane 0.
  k_lane_dec_t1 #(
    .ratio (ratio),
    .cnt_w (CW)
  ) u_lane_dec (
    .cnt     (cnt_q),
    .we      (rget),
    .lane_en (lane_en)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    odata_d      = odata_q;
    okeep_d      = okeep_q;

    if (state_q == EMIT && oready) begin
      odata_d = '0;
      okeep_d = '0;
    end
    for (int k = 0; k < ratio; k++) begin
      if (lane_en[k]) begin
        odata_d[k*data_size +: data_size] = rdata;
        okeep_d[k]                        = 1'b1;
      end
    end

    case (state_q)
      COLLECT: begin
        cnt_d = cnt_q + CW'(rget);
        if ((rget && cnt_q == LAST) || (flush_req && (cnt_q != '0 || rget))) begin
          state_d      = EMIT;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end else if (flush_req) begin
          flush_pend_d = 1'b0;
        end
      end
      EMIT: begin
        if (oready) begin
          if (rget && flush_req) begin
            state_d      = EMIT;
            cnt_d        = '0;
            flush_pend_d = 1'b0;
          end else begin
            state_d      = COLLECT;
            cnt_d        = CW'(rget);
            flush_pend_d = flush_req;
          end
        end else begin
          flush_pend_d = flush_pend_q || flush;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      odata_q      <= '0;
      okeep_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      odata_q      <= odata_d;
      okeep_q      <= okeep_d;
    end
  end

  assign odata  = odata_q;
  assign okeep  = okeep_q;
  assign ovalid = (state_q == EMIT);

endmodule

// File: tb/tb_k_rpack_t1.sv
// Directed and randomized-gap checks of the width packer at data_size=8, ratio=4.
module tb_k_rpack_t1;

  logic        clk;
  logic        rst;
  logic [7:0]  rdata;
  logic        rrdy;
  logic        rget;
  logic        flush;
  logic [31:0] odata;
  logic [3:0]  okeep;
  logic        ovalid;
  logic        oready;

  int n_cmp;
  int n_err;

  k_rpack_t1 #(.data_size(8), .ratio(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .rdata  (rdata),
    .rrdy   (rrdy),
    .rget   (rget),
    .flush  (flush),
    .odata  (odata),
    .okeep  (okeep),
    .ovalid (ovalid),
    .oready (oready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rrdy = 1'b1; rdata = 8'h99; flush = 1'b0; oready = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++;
    if (rget !== 1'b0) begin n_err++; $display("FAIL reset_rget got=%b want=0", rget); end
    tick();
    n_cmp++;
    if (ovalid !== 1'b0 || okeep !== 4'h0 || odata !== 32'h0) begin
      n_err++; $display("FAIL reset_outputs got v=%b k=%h d=%h want 0/0/0", ovalid, okeep, odata);
    end
    rrdy = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_full_word();
    logic [7:0] v [4];
    v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33; v[3] = 8'h44;
    oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rrdy = 1'b1; rdata = v[i];
      @(negedge clk);
      n_cmp++;
      if (rget !== 1'b1) begin n_err++; $display("FAIL full_rget%0d got=%b want=1", i, rget); end
      tick();
    end
    rrdy = 1'b0;
    n_cmp++;
    if (ovalid !== 1'b1 || odata !== 32'h44332211 || okeep !== 4'b1111) begin
      n_err++; $display("FAIL full_word got v=%b d=%h k=%b want 1/44332211/1111", ovalid, odata, okeep);
    end
    tick();
    n_cmp++;
    if (ovalid !== 1'b0 || okeep !== 4'b0000) begin
      n_err++; $display("FAIL full_drain got v=%b k=%b want 0/0000", ovalid, okeep);
    end
  endtask

  task automatic test_backpressure();
    oready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rrdy = 1'b1; rdata = 8'(i + 1);
      tick();
    end
    rdata = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rget !== 1'b0 || ovalid !== 1'b1 || odata !== 32'h04030201) begin
        n_err++; $display("FAIL bp_hold%0d got rget=%b v=%b d=%h want 0/1/04030201", i, rget, ovalid, odata);
      end
      tick();
    end
    oready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rget !== 1'b1) begin n_err++; $display("FAIL bp_release_rget got=%b want=1", rget); end
    tick();
    rrdy = 1'b0;
    n_cmp++;
    if (ovalid !== 1'b0 || okeep !== 4'b0001 || odata !== 32'h00000055) begin
      n_err++; $display("FAIL bp_next_lane0 got v=%b k=%b d=%h want 0/0001/00000055", ovalid, okeep, odata);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (ovalid !== 1'b1 || okeep !== 4'b0001 || odata !== 32'h00000055) begin
      n_err++; $display("FAIL bp_flush_word got v=%b k=%b d=%h want 1/0001/00000055", ovalid, okeep, odata);
    end
    tick();
  endtask

  task automatic test_partial_flush();
    oready = 1'b1;
    rrdy = 1'b1; rdata = 8'hAA; tick();
    rdata = 8'hBB; tick();
    rrdy = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    n_cmp++;
    if (ovalid !== 1'b1 || odata !== 32'h0000BBAA || okeep !== 4'b0011) begin
      n_err++; $display("FAIL partial_flush got v=%b d=%h k=%b want 1/0000BBAA/0011", ovalid, odata, okeep);
    end
    tick();
  endtask

  task automatic test_flush_corners();
    rrdy = 1'b0; oready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (ovalid !== 1'b0) begin n_err++; $display("FAIL flush_empty_a got=%b want=0", ovalid); end
    tick();
    n_cmp++;
    if (ovalid !== 1'b0) begin n_err++; $display("FAIL flush_empty_b got=%b want=0", ovalid); end

    rrdy = 1'b1; rdata = 8'h01; tick();
    rdata = 8'h02; tick();
    rdata = 8'h03; flush = 1'b1; tick();
    rrdy = 1'b0; flush = 1'b0;
    n_cmp++;
    if (ovalid !== 1'b1 || okeep !== 4'b0111 || odata !== 32'h00030201) begin
      n_err++; $display("FAIL flush_with_pop got v=%b k=%b d=%h want 1/0111/00030201", ovalid, okeep, odata);
    end
    tick();

    oready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rrdy = 1'b1; rdata = 8'hA1 + 8'(i); tick();
    end
    rrdy = 1'b0;
    n_cmp++;
    if (ovalid !== 1'b1 || odata !== 32'hA4A3A2A1) begin
      n_err++; $display("FAIL emit_flush_first got v=%b d=%h want 1/A4A3A2A1", ovalid, odata);
    end
    flush = 1'b1; tick();
    flush = 1'b0; oready = 1'b1; rrdy = 1'b1; rdata = 8'h66;
    tick();
    rrdy = 1'b0;
    n_cmp++;
    if (ovalid !== 1'b1 || odata !== 32'h00000066 || okeep !== 4'b0001) begin
      n_err++; $display("FAIL emit_flush_second got v=%b d=%h k=%b want 1/00000066/0001", ovalid, odata, okeep);
    end
    tick();
    n_cmp++;
    if (ovalid !== 1'b0) begin n_err++; $display("FAIL emit_flush_drain got=%b want=0", ovalid); end
  endtask

  task automatic test_reset_mid_word();
    oready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rrdy = 1'b1; rdata = 8'(i + 1); tick();
    end
    rrdy = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    n_cmp++;
    if (ovalid !== 1'b0 || okeep !== 4'b0000 || odata !== 32'h0) begin
      n_err++; $display("FAIL rst_mid got v=%b k=%b d=%h want 0/0000/0", ovalid, okeep, odata);
    end
    for (int i = 0; i < 4; i++) begin
      rrdy = 1'b1; rdata = 8'(i + 5); tick();
    end
    rrdy = 1'b0;
    n_cmp++;
    if (ovalid !== 1'b1 || odata !== 32'h08070605 || okeep !== 4'b1111) begin
      n_err++; $display("FAIL rst_fresh_word got v=%b d=%h k=%b want 1/08070605/1111", ovalid, odata, okeep);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    oready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rrdy = 1'b1; rdata = 8'h10 + 8'(i);
      @(negedge clk);
      n_cmp++;
      if (rget !== 1'b1) begin n_err++; $display("FAIL b2b_rget%0d got=%b want=1", i, rget); end
      tick();
      if (i == 3) begin
        n_cmp++;
        if (ovalid !== 1'b1 || odata !== 32'h13121110) begin
          n_err++; $display("FAIL b2b_word1 got v=%b d=%h want 1/13121110", ovalid, odata);
        end
      end
    end
    rrdy = 1'b0;
    n_cmp++;
    if (ovalid !== 1'b1 || odata !== 32'h17161514 || okeep !== 4'b1111) begin
      n_err++; $display("FAIL b2b_word2 got v=%b d=%h k=%b want 1/17161514/1111", ovalid, odata, okeep);
    end
    tick();
  endtask

  task automatic test_random_gaps();
    int src;
    int exp_n;
    int cyc;
    int bad_rget;
    logic popped;
    logic gap;
    logic word_ok;
    src = 0; exp_n = 0; cyc = 0; bad_rget = 0;
    while (exp_n < 1000 && cyc < 30000) begin
      rrdy   = (src < 1000) && ($urandom_range(0, 3) != 0);
      rdata  = src[7:0];
      oready = ($urandom_range(0, 2) != 0);
      flush  = ($urandom_range(0, 15) == 0) || (src >= 1000);
      @(negedge clk);
      if (rget && !rrdy) bad_rget++;
      popped = rget;
      if (ovalid && oready) begin
        gap = 1'b0;
        word_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
          if (okeep[k]) begin
            if (gap || odata[k*8 +: 8] !== exp_n[7:0]) word_ok = 1'b0;
            exp_n++;
          end else begin
            gap = 1'b1;
            if (odata[k*8 +: 8] !== 8'h00) word_ok = 1'b0;
          end
        end
        n_cmp++;
        if (!word_ok || okeep == 4'b0000) begin
          n_err++; $display("FAIL rand_word got d=%h k=%b next_expected=%0d", odata, okeep, exp_n);
        end
      end
      tick();
      if (popped) src++;
      cyc++;
    end
    rrdy = 1'b0; flush = 1'b0; oready = 1'b1;
    n_cmp++;
    if (exp_n != 1000) begin n_err++; $display("FAIL rand_count got=%0d want=1000", exp_n); end
    n_cmp++;
    if (bad_rget != 0) begin n_err++; $display("FAIL rand_rget_no_rrdy got=%0d want=0", bad_rget); end
    tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; rrdy = 1'b0; rdata = '0; flush = 1'b0; oready = 1'b0;
    test_reset();
    test_full_word();
    test_backpressure();
    test_partial_flush();
    test_flush_corners();
    test_reset_mid_word();
    test_back_to_back();
    test_random_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/k_rpack_t1.md
# k_rpack_t1

Read-side width packer placed directly downstream of the 2-deep clock-domain-crossing FIFO, in the read clock domain. Pops `data_size`-bit entries through the FIFO's `rrdy`/`rget` handshake and assembles `ratio` consecutive entries into one wide word with a lane-keep mask. Presents the word on a valid/ready output. A `flush` request closes a partial word early.

## Interface
Parameters:
- `data_size`, 8: entry width, matching the FIFO `data_size`.
- `ratio`, 4: entries per output word, ≥2. Counter width is clog2(`ratio`)+1.

Ports:
- `clk` in 1: read-domain clock, the FIFO's `rclk`.
- `rst` in 1: reset, synchronous, active-high.
- `rdata` in `data_size`: FIFO head entry, valid while `rrdy`=1.
- `rrdy` in 1: FIFO holds an entry.
- `rget` out 1: pop strobe, one cycle per entry consumed.
- `flush` in 1: single-cycle request to emit the partial word.
- `odata` out `data_size*ratio`: packed word. Lane k is bits [k*data_size +: data_size].
- `okeep` out `ratio`: bit k=1 means lane k holds a real entry.
- `ovalid` out 1: word valid.
- `oready` in 1: consumer accepts the word.

## Operation
- States:
  - COLLECT: filling; `ovalid`=0.
  - EMIT: word held; `ovalid`=1.
- Registers: `cnt` (entries in the current word), `flush_pend`.
- `acc` = `(state==COLLECT) | (state==EMIT & oready)`.
- `rget` = `rrdy & acc & ~rst`. It is combinational from registers and inputs.
- On `rget`, `rdata` is written into lane `cnt`, `okeep[cnt]` is set, and `cnt` increments. The first entry goes into lane 0 (little-endian).
- COLLECT → EMIT when either:
  - the entry popped this cycle fills lane `ratio-1`, or
  - the flush request (`flush | flush_pend`) is active, with `cnt`>0 or an entry popped this cycle.
  - In both cases `cnt` is cleared and `flush_pend` is cleared.
- A flush with `cnt`=0 and no pop is dropped. `flush_pend` is cleared and there is no output.
- A flush in the same cycle as a pop includes the popped entry in the emitted word.
- Unfilled lanes of an emitted word read 0.
- EMIT with `oready`=1: the handshake completes. `odata`/`okeep` are cleared to 0 except for an entry popped in the same cycle, which lands in lane 0 of the next word. State → COLLECT, unless that popped entry plus a pending flush closes a word again.
- EMIT with `oready`=0: `odata`, `okeep`, and `ovalid` are held stable and `rget`=0.
- `flush` asserted during EMIT sets `flush_pend`, which is evaluated in the following COLLECT evaluation.
- Reset:
  - Values: state=COLLECT, `cnt`=0, `flush_pend`=0, `odata`=0, `okeep`=0, `ovalid`=0, `rget`=0.
  - A partial word is discarded. No FIFO entry is popped while `rst`=1.

## Timing
- `ovalid` rises 1 cycle after the `rget` that fills lane `ratio-1`, or 1 cycle after an accepted flush.
- Maximum throughput is one entry per cycle. A word completes every `ratio` cycles with no bubble when `oready`=1, because the handshake cycle also pops the next entry.
- `ovalid` falls the cycle after the `ovalid & oready` handshake, unless a new word closed in that cycle.
- `rget` is never high while `rrdy`=0. It rises in the same cycle `rrdy` rises if `acc`=1.
- Simultaneous pop of lane `ratio-1` and `flush`: a single full word is emitted, `okeep` all ones. There is no extra empty word.

## Structure
- Package `k_rpack_pkg_t1` holds:
  - state encodings COLLECT=1'b0 and EMIT=1'b1;
  - a clog2 function for the `cnt` width.
- Sub-module `k_lane_dec_t1`: decodes `cnt` plus the write strobe into a one-hot `ratio`-bit lane enable. It is shared by the `odata` lane write and the `okeep` set.
- Everything else is flat: one state register, `cnt`, `flush_pend`, the `odata`/`okeep` registers, and the combinational `rget`.

## Test plan
All tests use `data_size`=8 and `ratio`=4.
- Full word: `rrdy` held high, entries 11, 22, 33, 44, `oready`=1 → 4 `rget` pulses. `odata`=0x44332211, `okeep`=4'b1111, `ovalid` high one cycle after the 4th `rget`.
- Backpressure: word pending with `oready`=0 for 5 cycles and `rrdy`=1 → `odata` held and `rget`=0 throughout. When `oready` rises, `rget`=1 in that same cycle and entry 55 goes to lane 0 of the next word.
- Partial flush: entries AA, BB, then `flush` → `odata`=0x0000BBAA, `okeep`=4'b0011.
- Flush corners:
  - `flush` with `cnt`=0 → `ovalid` stays 0.
  - `flush` in the same cycle as the 3rd pop → `okeep`=4'b0111.
  - `flush` during EMIT, then one entry 66 → second word `odata`=0x00000066, `okeep`=4'b0001.
- Reset mid-word: 3 entries popped, `rst` pulsed → `ovalid`=0 and `okeep`=0. The next 4 entries form a fresh full word starting at lane 0.
- Random `rrdy`/`oready` gaps with 1000 entries → the scoreboard sees every entry exactly once, in order, with no `rget` while `rrdy`=0.
